// File: rtl/fluxo_dados_drone.sv
// Datapath for the drone game: button edge detection, position and step registers,
// obstacle lookup, lives bookkeeping and the mode-dependent timeout counter.
module fluxo_dados_drone #(
  parameter int TEMPO_LENTO  = 5000,
  parameter int TEMPO_RAPIDO = 2500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       zeraPosicoes,
  input  logic       zeraT,
  input  logic       contaT,
  input  logic       escolhe_modo,
  input  logic       escolhe_vida,
  input  logic       resetaVidas,
  input  logic       desloca,
  input  logic       atualiza,
  input  logic       checa_colisao,
  input  logic [1:0] botoes,
  input  logic       modo_sel,
  input  logic [1:0] vidas_sel,
  output logic       timeout,
  output logic       fim_mapa,
  output logic       colisao,
  output logic       borda_movimento,
  output logic [2:0] db_altura,
  output logic [3:0] db_passo,
  output logic [1:0] db_vidas,
  output logic       db_modo
);

  localparam logic [15:0] LIM_LENTO  = 16'(TEMPO_LENTO - 1);
  localparam logic [15:0] LIM_RAPIDO = 16'(TEMPO_RAPIDO - 1);
  localparam logic [2:0]  ALTURA_INICIAL = 3'd3;

  logic        modo_reg,   modo_next;
  logic [1:0]  vidas_reg,  vidas_next;
  logic [2:0]  altura_reg, altura_next;
  logic [3:0]  passo_reg,  passo_next;
  logic [15:0] tempo_reg,  tempo_next;
  logic        dir_reg,    dir_next;
  logic [1:0]  b_s1_reg, b_s2_reg, b_prev_reg;

  logic [1:0]  nova;
  logic        obst_valid;
  logic [2:0]  obst_altura;
  logic        acerto;
  logic        perde_vida;
  logic [15:0] limite_m1;

  // Rising edges only; a simultaneous press of both buttons is ambiguous and ignored.
  assign nova            = b_s2_reg & ~b_prev_reg;
  assign borda_movimento = desloca & ((nova == 2'b10) | (nova == 2'b01));

  // Obstacle map: blocked height for each column, first and last columns free.
  always_comb begin
    obst_valid  = 1'b1;
    obst_altura = 3'd0;
    case (passo_reg)
      4'd0:    obst_valid  = 1'b0;
      4'd1:    obst_altura = 3'd4;
      4'd2:    obst_altura = 3'd2;
      4'd3:    obst_altura = 3'd6;
      4'd4:    obst_altura = 3'd1;
      4'd5:    obst_altura = 3'd4;
      4'd6:    obst_altura = 3'd0;
      4'd7:    obst_altura = 3'd7;
      4'd8:    obst_altura = 3'd3;
      4'd9:    obst_altura = 3'd5;
      4'd10:   obst_altura = 3'd2;
      4'd11:   obst_altura = 3'd6;
      4'd12:   obst_altura = 3'd1;
      4'd13:   obst_altura = 3'd4;
      4'd14:   obst_altura = 3'd3;
      default: obst_valid  = 1'b0;
    endcase
  end

  assign acerto     = obst_valid & (altura_reg == obst_altura);
  assign colisao    = checa_colisao & acerto & (vidas_reg == 2'd1);
  assign perde_vida = checa_colisao & acerto & (vidas_reg > 2'd1);

  assign limite_m1 = modo_reg ? LIM_RAPIDO : LIM_LENTO;
  assign timeout   = (tempo_reg >= limite_m1);
  assign fim_mapa  = (passo_reg == 4'd15);

  always_comb begin
    modo_next = modo_reg;
    if (escolhe_modo)
      modo_next = modo_sel;
  end

  always_comb begin
    vidas_next = vidas_reg;
    if (resetaVidas)
      vidas_next = 2'd1;
    else if (escolhe_vida)
      vidas_next = (vidas_sel == 2'd0) ? 2'd1 : vidas_sel;
    else if (perde_vida)
      vidas_next = vidas_reg - 2'd1;
  end

  always_comb begin
    dir_next = dir_reg;
    if (borda_movimento)
      dir_next = nova[1];
  end

  // Movement uses the direction latched before this edge, saturating at both ends.
  always_comb begin
    altura_next = altura_reg;
    passo_next  = passo_reg;
    if (zeraPosicoes) begin
      altura_next = ALTURA_INICIAL;
      passo_next  = 4'd0;
    end else if (atualiza) begin
      if (dir_reg)
        altura_next = (altura_reg == 3'd7) ? 3'd7 : altura_reg + 3'd1;
      else
        altura_next = (altura_reg == 3'd0) ? 3'd0 : altura_reg - 3'd1;
      passo_next = (passo_reg == 4'd15) ? 4'd15 : passo_reg + 4'd1;
    end
  end

  always_comb begin
    tempo_next = tempo_reg;
    if (zeraT)
      tempo_next = 16'd0;
    else if (contaT && (tempo_reg < limite_m1))
      tempo_next = tempo_reg + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      modo_reg   <= 1'b0;
      vidas_reg  <= 2'd1;
      altura_reg <= ALTURA_INICIAL;
      passo_reg  <= 4'd0;
      tempo_reg  <= 16'd0;
      dir_reg    <= 1'b0;
      b_s1_reg   <= 2'b00;
      b_s2_reg   <= 2'b00;
      b_prev_reg <= 2'b00;
    end else begin
      modo_reg   <= modo_next;
      vidas_reg  <= vidas_next;
      altura_reg <= altura_next;
      passo_reg  <= passo_next;
      tempo_reg  <= tempo_next;
      dir_reg    <= dir_next;
      b_s1_reg   <= botoes;
      b_s2_reg   <= b_s1_reg;
      b_prev_reg <= b_s2_reg;
    end
  end

  assign db_altura = altura_reg;
  assign db_passo  = passo_reg;
  assign db_vidas  = vidas_reg;
  assign db_modo   = modo_reg;

endmodule

// File: tb/tb_fluxo_dados_drone.sv
// Randomized and directed bench for fluxo_dados_drone against a cycle-level
// behavioural model of the game rules.
module tb_fluxo_dados_drone;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       zeraPosicoes = 0, zeraT = 0, contaT = 0, escolhe_modo = 0, escolhe_vida = 0;
  logic       resetaVidas = 0, desloca = 0, atualiza = 0, checa_colisao = 0;
  logic [1:0] botoes = 2'b00;
  logic       modo_sel = 0;
  logic [1:0] vidas_sel = 2'd0;
  logic       timeout, fim_mapa, colisao, borda_movimento;
  logic [2:0] db_altura;
  logic [3:0] db_passo;
  logic [1:0] db_vidas;
  logic       db_modo;

  always #5 clock = ~clock;

  fluxo_dados_drone #(.TEMPO_LENTO(10), .TEMPO_RAPIDO(5)) dut (
    .clock(clock), .reset(reset),
    .zeraPosicoes(zeraPosicoes), .zeraT(zeraT), .contaT(contaT),
    .escolhe_modo(escolhe_modo), .escolhe_vida(escolhe_vida), .resetaVidas(resetaVidas),
    .desloca(desloca), .atualiza(atualiza), .checa_colisao(checa_colisao),
    .botoes(botoes), .modo_sel(modo_sel), .vidas_sel(vidas_sel),
    .timeout(timeout), .fim_mapa(fim_mapa), .colisao(colisao),
    .borda_movimento(borda_movimento),
    .db_altura(db_altura), .db_passo(db_passo), .db_vidas(db_vidas), .db_modo(db_modo)
  );

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  // Game state as plain numbers; bq holds the button value seen at each of the last three edges.
  int m_modo, m_vidas, m_alt, m_passo, m_cnt, m_dir;
  logic [1:0] bq[$];
  int rom[16] = '{-1, 4, 2, 6, 1, 4, 0, 7, 3, 5, 2, 6, 1, 4, 3, -1};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_nova();
    return bq[1] & ~bq[0];
  endfunction

  function automatic int m_hit();
    return (rom[m_passo] >= 0 && m_alt == rom[m_passo]) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_modo = 0; m_vidas = 1; m_alt = 3; m_passo = 0; m_cnt = 0; m_dir = 0;
    bq = '{2'b00, 2'b00, 2'b00};
  endtask

  task automatic model_edge();
    logic [1:0] nv;
    int lim;
    int n_alt, n_passo, n_dir, n_modo, n_vidas, n_cnt;
    nv = m_nova();
    lim = m_modo ? 5 : 10;
    n_alt = m_alt; n_passo = m_passo; n_dir = m_dir;
    n_modo = m_modo; n_vidas = m_vidas; n_cnt = m_cnt;
    if (zeraPosicoes) begin
      n_alt = 3; n_passo = 0;
    end else if (atualiza) begin
      n_alt = m_dir ? ((m_alt < 7) ? m_alt + 1 : 7) : ((m_alt > 0) ? m_alt - 1 : 0);
      n_passo = (m_passo < 15) ? m_passo + 1 : 15;
    end
    if (desloca && (nv == 2'b01 || nv == 2'b10)) n_dir = (nv == 2'b10) ? 1 : 0;
    if (escolhe_modo) n_modo = int'(modo_sel);
    if (resetaVidas) n_vidas = 1;
    else if (escolhe_vida) n_vidas = (vidas_sel == 2'd0) ? 1 : int'(vidas_sel);
    else if (checa_colisao && m_hit() == 1 && m_vidas > 1) n_vidas = m_vidas - 1;
    if (zeraT) n_cnt = 0;
    else if (contaT && m_cnt < lim - 1) n_cnt = m_cnt + 1;
    m_alt = n_alt; m_passo = n_passo; m_dir = n_dir;
    m_modo = n_modo; m_vidas = n_vidas; m_cnt = n_cnt;
    bq.push_back(botoes);
    void'(bq.pop_front());
  endtask

  // Called just after a rising edge with inputs already driven; checks mid-cycle, then advances.
  task automatic step();
    logic [1:0] nv;
    int lim, eb, ec;
    #3;
    nv  = m_nova();
    lim = m_modo ? 5 : 10;
    eb  = (desloca && (nv == 2'b01 || nv == 2'b10)) ? 1 : 0;
    ec  = (checa_colisao && m_hit() == 1 && m_vidas == 1) ? 1 : 0;
    check("borda", borda_movimento, eb);
    check("colisao", colisao, ec);
    check("timeout", timeout, (m_cnt >= lim - 1) ? 1 : 0);
    check("fim_mapa", fim_mapa, (m_passo == 15) ? 1 : 0);
    check("altura", db_altura, m_alt);
    check("passo", db_passo, m_passo);
    check("vidas", db_vidas, m_vidas);
    check("modo", db_modo, m_modo);
    if (borda_movimento) pulses++;
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle();
    zeraPosicoes = 0; zeraT = 0; contaT = 0; escolhe_modo = 0; escolhe_vida = 0;
    resetaVidas = 0; desloca = 0; atualiza = 0; checa_colisao = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_timeout", timeout, 0);
    check("rst_fim", fim_mapa, 0);
    check("rst_colisao", colisao, 0);
    check("rst_borda", borda_movimento, 0);
    check("rst_altura", db_altura, 3);
    check("rst_passo", db_passo, 0);
    check("rst_vidas", db_vidas, 1);
    check("rst_modo", db_modo, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic set_dir(input int up);
    desloca = 1; botoes = 2'b00;
    repeat (3) step();
    botoes = up ? 2'b10 : 2'b01;
    repeat (4) step();
    botoes = 2'b00; desloca = 0;
    repeat (2) step();
  endtask

  task automatic move(input int n);
    atualiza = 1;
    repeat (n) step();
    atualiza = 0;
  endtask

  initial begin
    int k;
    model_reset();
    do_reset();

    // Single press held: one pulse, then an upward move.
    pulses = 0; desloca = 1; botoes = 2'b10;
    repeat (20) step();
    check("edge_once", pulses, 1);
    botoes = 2'b00; desloca = 0;
    move(1);
    check("up_altura", db_altura, 4);
    check("up_passo", db_passo, 1);

    // Both buttons together, and a press while desloca is low, are ignored.
    repeat (3) step();
    pulses = 0; desloca = 1; botoes = 2'b11;
    repeat (6) step();
    check("both_no_edge", pulses, 0);
    botoes = 2'b00;
    repeat (3) step();
    pulses = 0; desloca = 0; botoes = 2'b01;
    repeat (6) step();
    check("nodesloca_no_edge", pulses, 0);
    botoes = 2'b00;
    repeat (3) step();
    move(1);
    check("dir_kept", db_altura, 5);

    // Collision costs a life while more than one remains, then reports.
    zeraPosicoes = 1; resetaVidas = 1; step(); idle();
    escolhe_vida = 1; vidas_sel = 2'd2; step(); idle();
    check("vidas_loaded", db_vidas, 2);
    set_dir(1);
    move(1);
    checa_colisao = 1; #2;
    check("hit_with_lives", colisao, 0);
    step(); checa_colisao = 0;
    check("life_lost", db_vidas, 1);
    zeraPosicoes = 1; step(); zeraPosicoes = 0;
    move(1);
    checa_colisao = 1; #2;
    check("hit_last_life", colisao, 1);
    step(); checa_colisao = 0;

    // Walk to the end of the map going down.
    zeraPosicoes = 1; step(); zeraPosicoes = 0;
    set_dir(0);
    move(15);
    check("sat_altura", db_altura, 0);
    check("end_passo", db_passo, 15);
    check("end_fim", fim_mapa, 1);
    move(1);
    check("end_passo_hold", db_passo, 15);

    // Timeout in slow and fast mode.
    escolhe_modo = 1; modo_sel = 0; zeraT = 1; step(); idle();
    contaT = 1;
    for (k = 0; k < 30; k++) begin
      if (timeout) break;
      step();
    end
    check("timeout_lento", k, 9);
    contaT = 0; escolhe_modo = 1; modo_sel = 1; zeraT = 1; step(); idle();
    contaT = 1;
    for (k = 0; k < 30; k++) begin
      if (timeout) break;
      step();
    end
    check("timeout_rapido", k, 4);
    zeraT = 1; step(); idle();
    check("zerat_wins", timeout, 0);

    // Reach altura 6 / passo 7 / vidas 3, then reset mid-move.
    zeraPosicoes = 1; escolhe_vida = 1; vidas_sel = 2'd3; step(); idle();
    set_dir(1); move(6);
    set_dir(0); move(1);
    check("pre_rst_altura", db_altura, 6);
    check("pre_rst_passo", db_passo, 7);
    check("pre_rst_vidas", db_vidas, 3);
    desloca = 1; botoes = 2'b10; atualiza = 1;
    step();
    idle(); botoes = 2'b00;
    do_reset();
    repeat (4) step();

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      desloca       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) botoes = 2'($urandom_range(0, 3));
      atualiza      = ($urandom_range(0, 3) == 0);
      zeraPosicoes  = ($urandom_range(0, 19) == 0);
      zeraT         = ($urandom_range(0, 24) == 0);
      contaT        = 1'($urandom_range(0, 1));
      escolhe_modo  = ($urandom_range(0, 15) == 0);
      modo_sel      = 1'($urandom_range(0, 1));
      escolhe_vida  = ($urandom_range(0, 19) == 0);
      vidas_sel     = 2'($urandom_range(0, 3));
      resetaVidas   = ($urandom_range(0, 29) == 0);
      checa_colisao = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 199) == 0) do_reset();
      else step();
    end
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
